// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: round-robin grant of up to two reads per cycle onto the
// two RF read ports, registered read return, and a one-deep write buffer with read bypass.
module regfile_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          rd_req,
    input  logic [NREQ*ADDR_W-1:0]   rd_addr,
    output logic [NREQ-1:0]          rd_gnt,
    output logic [NREQ-1:0]          rd_rvalid,
    output logic [NREQ*DATA_W-1:0]   rd_rdata,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic [ADDR_W-1:0]        rf_raddr1,
    output logic [ADDR_W-1:0]        rf_raddr2,
    input  logic [DATA_W-1:0]        rf_rdata1,
    input  logic [DATA_W-1:0]        rf_rdata2,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]        r_rr_ptr;
    logic [1:0]              r_s_vld;
    logic [PTR_W-1:0]        r_s_own  [2];
    logic [ADDR_W-1:0]       r_s_addr [2];
    logic                    r_wb_vld;
    logic [ADDR_W-1:0]       r_wb_addr;
    logic [DATA_W-1:0]       r_wb_data;
    logic [NREQ-1:0]         r_rvalid;
    logic [NREQ*DATA_W-1:0]  r_rdata;

    logic [NREQ-1:0]         w_gnt;
    logic [1:0]              w_cnt;
    logic [PTR_W-1:0]        w_idx;
    logic [PTR_W-1:0]        w_sel [2];
    logic [PTR_W-1:0]        w_last;
    logic [PTR_W-1:0]        w_next;
    logic [DATA_W-1:0]       w_sdata [2];
    logic                    w_wb_load;

    // Scan from the round-robin pointer; first two requesters found take slots 0 and 1.
    always_comb begin
        w_gnt    = '0;
        w_cnt    = '0;
        w_idx    = '0;
        w_sel[0] = '0;
        w_sel[1] = '0;
        w_last   = r_rr_ptr;
        for (int unsigned j = 0; j < NREQ; j++) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + j) % NREQ);
            if (rd_req[w_idx] && (w_cnt != 2'd2)) begin
                w_gnt[w_idx]      = 1'b1;
                w_sel[w_cnt[0]]   = w_idx;
                w_cnt             = w_cnt + 2'd1;
                w_last            = w_idx;
            end
        end
        w_next = PTR_W'((32'(w_last) + 32'd1) % NREQ);
    end

    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            if (r_s_addr[k] == '0)
                w_sdata[k] = '0;
            else if (r_wb_vld && (r_wb_addr == r_s_addr[k]))
                w_sdata[k] = r_wb_data;
            else
                w_sdata[k] = (k == 0) ? rf_rdata1 : rf_rdata2;
        end
    end

    assign w_wb_load = wr_req && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_s_vld     <= '0;
            r_s_own[0]  <= '0;
            r_s_own[1]  <= '0;
            r_s_addr[0] <= '0;
            r_s_addr[1] <= '0;
            r_wb_vld    <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_cnt != 2'd0)
                r_rr_ptr <= w_next;
            r_s_vld[0] <= (w_cnt != 2'd0);
            r_s_vld[1] <= (w_cnt == 2'd2);
            if (w_cnt != 2'd0) begin
                r_s_own[0]  <= w_sel[0];
                r_s_addr[0] <= rd_addr[w_sel[0]*ADDR_W +: ADDR_W];
            end
            if (w_cnt == 2'd2) begin
                r_s_own[1]  <= w_sel[1];
                r_s_addr[1] <= rd_addr[w_sel[1]*ADDR_W +: ADDR_W];
            end
            // Slots always belong to distinct requesters, so the two writes never collide.
            r_rvalid <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                if (r_s_vld[k]) begin
                    r_rvalid[r_s_own[k]]                   <= 1'b1;
                    r_rdata[r_s_own[k]*DATA_W +: DATA_W]   <= w_sdata[k];
                end
            end
            r_wb_vld <= w_wb_load;
            if (w_wb_load) begin
                r_wb_addr <= wr_addr;
                r_wb_data <= wr_data;
            end
        end
    end

    assign rd_gnt    = w_gnt;
    assign rd_rvalid = r_rvalid;
    assign rd_rdata  = r_rdata;
    assign wr_ack    = wr_req;
    assign rf_raddr1 = r_s_addr[0];
    assign rf_raddr2 = r_s_addr[1];
    assign rf_we     = r_wb_vld;
    assign rf_waddr  = r_wb_addr;
    assign rf_wdata  = r_wb_data;

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the register file's 2 read ports and 1 write port among the issue-side requesters: ALU reservation station operands A1/A2 and load buffer operands L1/L2 on the read side, CDB writeback on the write side.
- Sits between the reservation stations/CDB and the RegisterFile instance.
- Replaces the fixed-priority combinational selection with:
  - round-robin grant of up to 2 reads per cycle,
  - a pipelined read return,
  - a one-deep write buffer with read bypass.

Parameters:
- NREQ, 4, number of read requesters; index 0=A1, 1=A2, 2=L1, 3=L2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  NREQ  per-requester read request.
- rd_addr  in  NREQ*ADDR_W  per-requester read address; slice i belongs to requester i.
- rd_gnt  out  NREQ  combinational grant, same cycle as request.
- rd_rvalid  out  NREQ  registered read-data valid, 1-cycle pulse.
- rd_rdata  out  NREQ*DATA_W  registered read data; slice i belongs to requester i.
- wr_req  in  1  CDB writeback request.
- wr_addr  in  ADDR_W  writeback register.
- wr_data  in  DATA_W  writeback value.
- wr_ack  out  1  combinational, = wr_req; writes are never stalled.
- rf_raddr1  out  ADDR_W  RegisterFile read address, port 1.
- rf_raddr2  out  ADDR_W  RegisterFile read address, port 2.
- rf_rdata1  in  DATA_W  RegisterFile read data, port 1; combinational read.
- rf_rdata2  in  DATA_W  RegisterFile read data, port 2; combinational read.
- rf_we  out  1  RegisterFile write enable; RF writes on clk edge.
- rf_waddr  out  ADDR_W  RegisterFile write address.
- rf_wdata  out  DATA_W  RegisterFile write data.

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, both read-stage valids=0, write buffer empty.
  - rd_rvalid=0, rd_rdata=0, rf_we=0, rf_raddr1/2=0, rf_waddr=0, rf_wdata=0.
  - In-flight reads are dropped with no rvalid. A buffered write is lost.
- Grant, cycle N:
  - Scan requesters i = rr_ptr, rr_ptr+1, … mod NREQ.
  - First asserted rd_req wins slot 1; second asserted wins slot 2.
  - rd_gnt=1 only for these, at most 2 per cycle.
  - At the clk edge, latch slot k valid, owner index and address.
  - If any grant was issued, rr_ptr <= (index of last granted)+1 mod NREQ; otherwise rr_ptr is unchanged.
  - An ungranted requester holds rd_req and rd_addr stable. rd_req still high after a grant is a new request.
- Read stage, cycle N+1:
  - rf_raddr1/2 are driven from the latched slot addresses.
  - Slot data = 0 if address==0.
  - Else slot data = write-buffer data if the buffer is valid with matching address (bypass).
  - Else slot data = rf_rdata.
  - At the edge, rd_rdata[owner] <= data and rd_rvalid[owner] <= 1.
  - Valid in cycle N+2. Total grant-to-data latency = 2 cycles, full throughput of 2 reads/cycle.
- Write path:
  - wr_req in cycle M loads the buffer {addr,data} at the edge.
  - In cycle M+1: rf_we=1, rf_waddr/rf_wdata driven from the buffer. RF commits at the end of M+1.
  - Writes to x0: wr_ack=1, buffer not loaded, rf_we stays 0.
  - Back-to-back writes: the buffer reloads every cycle, giving 1 write/cycle.
- Read/write hazard:
  - A read latched in cycle N whose address matches a write accepted in cycle N sees the new value via the buffer bypass in N+1.
  - A read whose stage overlaps the commit cycle also bypasses.
  - A read latched after the commit sees the RF value.
- rd_rvalid bits not written in a cycle return to 0. rd_rdata holds its last value.

Test Plan:
- Reset then idle: rst_n low mid-run with slot valid → rd_rvalid=0, rf_we=0 immediately; after release rr_ptr=0.
- All 4 rd_req high, addrs 1,2,3,4, RF holds value=addr*16:
  - cycle 0: gnt=0011; cycle 1: gnt=1100.
  - rd_rdata = 0x10,0x20 in cycle 2 and 0x30,0x40 in cycle 3.
- Fairness: A1 and L2 requesting continuously for 6 cycles → each granted every cycle; single-requester L1 → granted every cycle, latency 2.
- Write-then-read bypass: cycle 0 wr_req addr 5 data 0xDEADBEEF and rd_req[2] addr 5 → rd_rdata[2]=0xDEADBEEF in cycle 2; rf_we=1 in cycle 1 with waddr 5.
- x0: wr_req addr 0 data 0x1234 → wr_ack=1, rf_we never 1; read addr 0 → rd_rdata=0.
- Back-to-back writes: addrs 6,7 with data 0x66,0x77 on cycles 0,1 → rf_we high in cycles 1,2 with matching addr/data.
